// File: rtl/da_fir_pkg.sv
// da_fir_pkg: FSM state encoding and default widths for the distributed-arithmetic FIR engine.
package da_fir_pkg;

  localparam int DA_TAPS   = 8;
  localparam int DA_LUT_AW = 4;
  localparam int DA_IN_W   = 16;
  localparam int DA_COEF_W = 16;
  localparam int DA_ACC_W  = 32;
  localparam int DA_OUT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } da_state_e;

endpackage

// File: rtl/da_lut_part.sv
// da_lut_part: one DA partition. Sums the LUT_AW coefficients whose address bit
// is set; address 0 yields 0. Purely combinational, so coefficient writes are
// visible without any table rebuild.
module da_lut_part #(
  parameter int LUT_AW = 4,
  parameter int COEF_W = 16,
  parameter int SUM_W  = 20
) (
  input  logic [LUT_AW*COEF_W-1:0] coefs_i,
  input  logic [LUT_AW-1:0]        addr_i,
  output logic signed [SUM_W-1:0]  sum_o
);

  // add each selected coefficient, sign-extended to the partition sum width
  always_comb begin
    sum_o = '0;
    for (int j = 0; j < LUT_AW; j++) begin
      if (addr_i[j]) begin
        sum_o = sum_o + SUM_W'($signed(coefs_i[j*COEF_W +: COEF_W]));
      end
    end
  end

endmodule

// File: rtl/da_fir_engine.sv
// da_fir_engine: bit-serial distributed-arithmetic FIR with runtime coefficients.
// One sample bit-plane is looked up per cycle (LSB first); the plane sum is
// registered and folded into the accumulator one cycle later, so the engine
// spends IN_W lookup cycles plus one drain cycle in CALC before presenting
// the result in HOLD.
// Build option: define DA_FIR_SAT_EN to saturate out_data to the signed OUT_W
// range; otherwise out_data is the low OUT_W accumulator bits.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// CALC  | bit-plane lookups and accumulation for the accepted sample
// HOLD  | result valid on out_data until out_ready
module da_fir_engine
  import da_fir_pkg::*;
#(
  parameter int TAPS   = DA_TAPS,
  parameter int LUT_AW = DA_LUT_AW,
  parameter int IN_W   = DA_IN_W,
  parameter int COEF_W = DA_COEF_W,
  parameter int ACC_W  = DA_ACC_W,
  parameter int OUT_W  = DA_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_err,
  output logic                    busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int NPART  = TAPS / LUT_AW;
  localparam int PSUM_W = COEF_W + $clog2(TAPS) + 1;
  localparam int PW     = $clog2(IN_W);
  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(IN_W);
  localparam logic [PW-1:0]    SIGN_PLANE = PW'(IN_W - 1);

  da_state_e               state_q, state_d;
  logic signed [IN_W-1:0]   x_q    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  psum_ext, weighted;
  logic signed [PSUM_W-1:0] psum_q;
  logic signed [PSUM_W-1:0] part_sum [NPART];
  logic signed [PSUM_W-1:0] lut_total;
  logic [CNT_W-1:0]         cnt_q, cnt_m1;
  logic [PW-1:0]            plane_idx, prev_plane;
  logic [OUT_W-1:0]         out_data_q, out_fmt;
  logic                     coef_err_q;
  logic                     accept;
  logic                     addr_ok;

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign plane_idx  = cnt_q[PW-1:0];
  assign cnt_m1     = cnt_q - CNT_W'(1);
  assign prev_plane = cnt_m1[PW-1:0];
  assign addr_ok    = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  // one partition lookup per group of LUT_AW taps, addressed by the current bit-plane
  for (genvar p = 0; p < NPART; p++) begin : g_part
    logic [LUT_AW-1:0]        addr;
    logic [LUT_AW*COEF_W-1:0] cvec;

    // gather this partition's sample bits and coefficients
    always_comb begin
      addr = '0;
      cvec = '0;
      for (int j = 0; j < LUT_AW; j++) begin
        addr[j]                   = x_q[p*LUT_AW+j][plane_idx];
        cvec[j*COEF_W +: COEF_W]  = coef_q[p*LUT_AW+j];
      end
    end

    da_lut_part #(
      .LUT_AW (LUT_AW),
      .COEF_W (COEF_W),
      .SUM_W  (PSUM_W)
    ) u_part (
      .coefs_i (cvec),
      .addr_i  (addr),
      .sum_o   (part_sum[p])
    );
  end

  // total of all partition lookups for the current plane
  always_comb begin
    lut_total = '0;
    for (int p = 0; p < NPART; p++) begin
      lut_total = lut_total + part_sum[p];
    end
  end

  // fold the previous plane's sum in with weight 2^k; the top plane carries negative weight
  always_comb begin
    psum_ext = ACC_W'(psum_q);
    weighted = psum_ext <<< prev_plane;
    acc_d    = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (state_q == ST_CALC && cnt_q != '0) begin
      acc_d = (prev_plane == SIGN_PLANE) ? (acc_q - weighted) : (acc_q + weighted);
    end
  end

`ifdef DA_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // clamp the final accumulator into the signed output range
  always_comb begin
    out_fmt = acc_d[OUT_W-1:0];
    if (acc_d > SAT_MAX) begin
      out_fmt = SAT_MAX[OUT_W-1:0];
    end else if (acc_d < SAT_MIN) begin
      out_fmt = SAT_MIN[OUT_W-1:0];
    end
  end
`else
  // output keeps the low accumulator bits
  always_comb begin
    out_fmt = acc_d[OUT_W-1:0];
  end
`endif

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)          state_d = ST_CALC;
      ST_CALC: if (cnt_q == LAST_CNT) state_d = ST_HOLD;
      ST_HOLD: if (out_ready)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // FSM, delay line, plane counter and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      psum_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        x_q[0] <= in_data;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        cnt_q <= '0;
      end
      if (state_q == ST_CALC) begin
        psum_q <= lut_total;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) out_data_q <= out_fmt;
      end
    end
  end

  // coefficient register file: writes only land while idle and in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else begin
      coef_err_q <= 1'b0;
      if (coef_we) begin
        if (state_q == ST_IDLE && addr_ok) begin
          coef_q[coef_addr] <= coef_data;
        end else begin
          coef_err_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_da_fir_engine.sv
// tb_da_fir_engine: directed checks of the DA FIR engine (impulse, sign plane,
// backpressure, coefficient write rejection, reset abort, output wrap/saturate).
module tb_da_fir_engine;

  localparam int TAPS = 8;
  localparam int COEFS [TAPS] = '{1, 1, -5, -12, 22, 39, -62, -94};
`ifdef DA_FIR_SAT_EN
  localparam longint SAT_FINAL = 32767;
`else
  localparam longint SAT_FINAL = 8;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err;
  logic        busy;

  int     checks = 0;
  int     errors = 0;
  longint tb_x [TAPS];
  longint tb_c [TAPS];

  da_fir_engine #(
    .TAPS   (8),
    .LUT_AW (4),
    .IN_W   (16),
    .COEF_W (16),
    .ACC_W  (40),
    .OUT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fmt16(input longint s);
`ifdef DA_FIR_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    logic signed [15:0] t;
    t = s[15:0];
    return longint'(t);
`endif
  endfunction

  // expected output if x were accepted next, from the bench's own tap/coef copy
  function automatic longint model_next(input int x);
    longint s;
    s = tb_c[0] * longint'(x);
    for (int i = 1; i < TAPS; i++) s += tb_c[i] * tb_x[i-1];
    return fmt16(s);
  endfunction

  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a[2:0];
    coef_data = d[15:0];
    @(negedge clk);
    coef_we   = 1'b0;
    tb_c[a]   = longint'(d);
  endtask

  task automatic run_sample(input int x, input longint exp, input int hold, input string tag);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b1;
    in_data  = x[15:0];
    @(posedge clk);
    for (int i = TAPS - 1; i > 0; i--) tb_x[i] = tb_x[i-1];
    tb_x[0] = longint'(x);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 17);
    check({tag, "_data"}, $signed(out_data), exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_data"}, $signed(out_data), exp);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release_in_ready"}, in_ready, 1);
    check({tag, "_release_valid"}, out_valid, 0);
  endtask

  initial begin
    int  lat;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    for (int i = 0; i < TAPS; i++) begin
      tb_x[i] = 0;
      tb_c[i] = 0;
    end
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_coef_err", coef_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < TAPS; i++) write_coef(i, COEFS[i]);

    // rejected coefficient write while computing
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd0;
    @(posedge clk);
    for (int i = TAPS - 1; i > 0; i--) tb_x[i] = tb_x[i-1];
    tb_x[0] = 0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd100;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_err_pulse", coef_err, 1);
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    @(negedge clk);
    check("coef_err_single", coef_err, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("coef_err_result", $signed(out_data), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // impulse response reproduces the coefficient list
    run_sample(1, COEFS[0], 0, "impulse_0");
    for (int i = 1; i < TAPS; i++) run_sample(0, COEFS[i], 0, $sformatf("impulse_%0d", i));

    // backpressure: x=2 with c0=1, held for 10 cycles
    run_sample(2, 2, 10, "backpressure");

    // reset in the middle of a computation
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_data", $signed(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      tb_x[i] = 0;
      tb_c[i] = 0;
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midreset_no_valid", seen, 0);
    run_sample(5, 0, 0, "after_reset");

    // sign plane
    write_coef(0, 1);
    run_sample(-32768, -32768, 0, "sign_neg");
    run_sample(32767, 32767, 0, "sign_pos");

    // large sums: wrap or saturate
    for (int i = 0; i < TAPS; i++) write_coef(i, 32767);
    for (int i = 0; i < TAPS - 1; i++) run_sample(32767, model_next(32767), 0, $sformatf("big_%0d", i));
    run_sample(32767, SAT_FINAL, 0, "big_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
